memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter RegBits, default 32, data and address width.
REQ-002 SHALL have parameter DepthBits, default 8, log2 of the word count (256 words).
REQ-003 SHALL have parameter Latency, default 2, request-accept to response-valid cycles; legal range 1..15.
REQ-004 SHALL have one clock and one asynchronous, active-low reset: clk_i input 1 (all state on rising edge), rst_i input 1 (async active-low reset).
REQ-005 SHALL have port req_valid_i, input, 1 bit: request present.
REQ-006 SHALL have port req_ready_o, output, 1 bit: responder can accept.
REQ-007 SHALL have port req_addr_i, input, RegBits: byte address.
REQ-008 SHALL have port req_write_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 SHALL have port req_wdata_i, input, RegBits: store data, right-aligned.
REQ-011 SHALL have port resp_valid_o, output, 1 bit: response present.
REQ-012 SHALL have port resp_ready_i, input, 1 bit: initiator takes the response.
REQ-013 SHALL have port resp_rdata_o, output, RegBits: load data, right-aligned, zero-extended.
REQ-014 SHALL have port resp_err_o, output, 1 bit: access error, qualified by resp_valid_o.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert req_ready_o only in IDLE; handshake = req_valid_i & req_ready_o.
REQ-017 SHALL, on handshake in cycle N, latch addr/write/size/wdata and load counter with Latency-1; next state WAIT if Latency>1, otherwise RESP.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where the counter equals 1; resp_valid_o first high in cycle N+Latency.
REQ-019 SHALL commit the memory access (store write or load capture) on the edge entering RESP, not earlier.
REQ-020 SHALL write only the addressed byte lanes: byte = lane addr[1:0], half = lanes addr[1]*2..+1, word = all lanes; other lanes unchanged.
REQ-021 SHALL, for loads, return the selected lanes shifted to bit 0 with upper bits zero; for stores, resp_rdata_o = 0.
REQ-022 SHALL index words by addr[DepthBits+1:2]; higher address bits ignored (wrap modulo depth).
REQ-023 SHALL, in RESP, hold resp_valid_o, resp_rdata_o and resp_err_o stable until resp_ready_i=1, then go to IDLE; req_ready_o high in the following cycle (no same-cycle request accept).
REQ-024 SHALL ignore req_valid_i outside IDLE, and ignore resp_ready_i outside RESP.

Reset
REQ-025 SHALL, while rst_i=0: state IDLE, counter 0, req_ready_o 0, resp_valid_o 0, resp_rdata_o 0, resp_err_o 0; memory array not cleared.
REQ-026 SHALL, on reset during WAIT, abort the access; a pending store SHALL NOT modify memory.
REQ-027 SHALL raise req_ready_o in the first cycle after rst_i deasserts.

Configuration
REQ-028 SHALL use macro RESP_ERR_EN; when defined, size 11 or misalignment (half with addr[0]=1, word with addr[1:0]!=0) gives resp_err_o=1, no write, resp_rdata_o=0, same Latency.
REQ-029 SHALL, when RESP_ERR_EN is undefined, tie resp_err_o to 0, treat size 11 as word, and align misaligned addresses down to the size boundary.

Structure
REQ-030 SHALL place the size encoding enum, the FSM state enum and LatencyMax=15 in shared package mem_pkg.
REQ-031 SHALL use one sub-module, mem_lane_align: combinational byte-enable, write-shift and read-extract from addr[1:0] and size.

Verification
REQ-032 SHALL verify: reset, word store 0xDEADBEEF @0x10, Latency=2, resp_ready_i=1 -> resp_valid_o in cycle N+2, then word load @0x10 returns 0xDEADBEEF.
REQ-033 SHALL verify: byte store 0xAA @0x13 over 0x11223344 -> word load = 0xAA223344; byte load @0x13 = 0x000000AA.
REQ-034 SHALL verify: load response with resp_ready_i held 0 for 5 cycles -> resp_valid_o and data stable, req_ready_o 0 throughout, req_ready_o 1 the cycle after accept.
REQ-035 SHALL verify: with Latency=4, store @0x20 with rst_i pulsed low in WAIT -> no response, old word at 0x20 unchanged, req_ready_o 1 after release.
REQ-036 SHALL verify: RESP_ERR_EN defined, half store @0x21 -> resp_err_o=1, memory unchanged; undefined -> resp_err_o=0, write lands at 0x20.
REQ-037 SHALL verify: with DepthBits=8, word store @0x400 -> load @0x000 returns the stored value (wrap).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: access size encoding, FSM states,
// the latency ceiling and the access-error rule used when RESP_ERR_EN is defined.
package mem_pkg;

   localparam int LatencyMax = 15;
   localparam int CntBits    = $clog2(LatencyMax + 1);

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Reserved size or an address not aligned to its size is an access error.
   function automatic logic access_error(input size_e size, input logic [1:0] lane);
      case (size)
         SIZE_HALF: return lane[0];
         SIZE_WORD: return lane != 2'b00;
         SIZE_RSVD: return 1'b1;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory responder: byte enables and write-data
// placement for stores, lane extraction with zero extension for loads.
// Half accesses use addr[1] only and word/reserved accesses use every lane,
// so misaligned addresses fall back to the enclosing size boundary.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int RegBits = 32
) (
   input  logic [1:0]           addr_lo,
   input  size_e                size,
   input  logic [RegBits-1:0]   wdata,
   input  logic [RegBits-1:0]   rword,
   output logic [RegBits/8-1:0] byte_en,
   output logic [RegBits-1:0]   wdata_shifted,
   output logic [RegBits-1:0]   rdata_ext
);

   localparam int NumLanes = RegBits / 8;

   // Decode lanes, move store data up to its lanes and load data down to bit 0.
   always_comb begin
      byte_en       = '1;
      wdata_shifted = wdata;
      rdata_ext     = rword;
      case (size)
         SIZE_BYTE: begin
            byte_en       = NumLanes'(1) << addr_lo;
            wdata_shifted = RegBits'(wdata[7:0]) << {addr_lo, 3'b000};
            rdata_ext     = RegBits'(rword[{addr_lo, 3'b000} +: 8]);
         end
         SIZE_HALF: begin
            byte_en       = NumLanes'(4'b0011) << {addr_lo[1], 1'b0};
            wdata_shifted = RegBits'(wdata[15:0]) << {addr_lo[1], 4'b0000};
            rdata_ext     = RegBits'(rword[{addr_lo[1], 4'b0000} +: 16]);
         end
         default: begin
            byte_en       = '1;
            wdata_shifted = wdata;
            rdata_ext     = rword;
         end
      endcase
   end

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder with a fixed request-to-response latency.
// One request is accepted in IDLE, counted down in WAIT and answered in RESP;
// the array is read or written on the edge that enters RESP.
// Optional feature macro: RESP_ERR_EN (reports misaligned/reserved-size accesses
// as errors instead of aligning them down).
// Latency must lie in 1..LatencyMax.
module memory_responder
   import mem_pkg::*;
#(
   parameter int RegBits   = 32,
   parameter int DepthBits = 8,
   parameter int Latency   = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [RegBits-1:0] req_addr_i,
   input  logic               req_write_i,
   input  logic [1:0]         req_size_i,
   input  logic [RegBits-1:0] req_wdata_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [RegBits-1:0] resp_rdata_o,
   output logic               resp_err_o
);

   localparam int                 NumLanes  = RegBits / 8;
   localparam int                 Words     = 1 << DepthBits;
   localparam int                 AddrBits  = DepthBits + 2;
   localparam logic [CntBits-1:0] CntLoad   = CntBits'(Latency - 1);
   localparam bit                 ShortPath = (Latency == 1);

   state_e               state_reg, state_next;
   logic [CntBits-1:0]   cnt_reg, cnt_next;
   logic                 ready_reg;
   logic [AddrBits-1:0]  addr_reg;
   logic                 write_reg;
   size_e                size_reg;
   logic [RegBits-1:0]   wdata_reg;
   logic                 err_reg;
   logic [RegBits-1:0]   rword_reg;
   logic [RegBits-1:0]   mem [Words];

   logic                 handshake;
   logic                 commit;
   logic                 use_req;
   logic                 mem_we;
   logic [AddrBits-1:0]  acc_addr;
   logic                 acc_write;
   size_e                acc_size;
   logic [RegBits-1:0]   acc_wdata;
   logic                 acc_err;
   logic [DepthBits-1:0] acc_idx;
   logic [NumLanes-1:0]  byte_en;
   logic [NumLanes-1:0]  lane_we;
   logic [RegBits-1:0]   wdata_shifted;
   logic [RegBits-1:0]   rdata_ext;
   logic                 unused_addr_bits;

   // Address bits above the array wrap and are deliberately ignored.
   assign unused_addr_bits = ^req_addr_i[RegBits-1:AddrBits];

   assign handshake = req_valid_i & ready_reg;

   // With a one-cycle latency the access commits on the accept edge itself,
   // before the request fields are latched, so the live request is used then.
   assign use_req   = ShortPath && (state_reg == ST_IDLE);
   assign acc_addr  = use_req ? req_addr_i[AddrBits-1:0] : addr_reg;
   assign acc_write = use_req ? req_write_i : write_reg;
   assign acc_size  = use_req ? size_e'(req_size_i) : size_reg;
   assign acc_wdata = use_req ? req_wdata_i : wdata_reg;
   assign acc_idx   = acc_addr[AddrBits-1:2];

   assign commit = ((state_reg == ST_WAIT) && (cnt_reg == CntBits'(1)))
                 || (ShortPath && handshake);

`ifdef RESP_ERR_EN
   assign acc_err    = access_error(acc_size, acc_addr[1:0]);
   assign resp_err_o = resp_valid_o & err_reg;
`else
   assign acc_err    = 1'b0;
   assign resp_err_o = 1'b0;
`endif

   // In RESP acc_* select the latched request, so the same instance serves
   // store steering on the commit edge and load extraction while responding.
   mem_lane_align #(
      .RegBits(RegBits)
   ) u_lane_align (
      .addr_lo       (acc_addr[1:0]),
      .size          (acc_size),
      .wdata         (acc_wdata),
      .rword         (rword_reg),
      .byte_en       (byte_en),
      .wdata_shifted (wdata_shifted),
      .rdata_ext     (rdata_ext)
   );

   assign mem_we = commit & acc_write & ~acc_err;

   for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane_we
      assign lane_we[gi] = mem_we & byte_en[gi];
   end

   // Next-state and countdown logic for the IDLE/WAIT/RESP sequence.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (handshake) begin
               cnt_next   = CntLoad;
               state_next = ShortPath ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg - CntBits'(1);
            if (cnt_reg == CntBits'(1)) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, countdown and ready flag; ready follows IDLE one edge late after reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ready_reg <= (state_next == ST_IDLE);
      end
   end

   // Capture the request on accept and the error flag on the commit edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_reg  <= '0;
         write_reg <= 1'b0;
         size_reg  <= SIZE_BYTE;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         if (handshake) begin
            addr_reg  <= req_addr_i[AddrBits-1:0];
            write_reg <= req_write_i;
            size_reg  <= size_e'(req_size_i);
            wdata_reg <= req_wdata_i;
         end
         if (commit) begin
            err_reg <= acc_err;
         end
      end
   end

   // Block RAM with per-lane write enables and a registered load read; never reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumLanes; i++) begin
         if (lane_we[i]) begin
            mem[acc_idx][i*8 +: 8] <= wdata_shifted[i*8 +: 8];
         end
      end
      if (commit && !acc_write) begin
         rword_reg <= mem[acc_idx];
      end
   end

   assign req_ready_o  = ready_reg;
   assign resp_valid_o = (state_reg == ST_RESP);
   assign resp_rdata_o = (resp_valid_o && !write_reg && !err_reg) ? rdata_ext : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one Latency=2 instance (index 0) and one
// Latency=4 instance (index 1) sharing the clock, each with its own ports.
`timescale 1ns/1ps
module tb_memory_responder;

   localparam int RegBits   = 32;
   localparam int DepthBits = 8;
`ifdef RESP_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic                    clk;
   logic [1:0]              rst_n;
   logic [1:0]              req_valid;
   logic [1:0]              req_ready;
   logic [1:0][RegBits-1:0] req_addr;
   logic [1:0]              req_write;
   logic [1:0][1:0]         req_size;
   logic [1:0][RegBits-1:0] req_wdata;
   logic [1:0]              resp_valid;
   logic [1:0]              resp_ready;
   logic [1:0][RegBits-1:0] resp_rdata;
   logic [1:0]              resp_err;

   int vectors     = 0;
   int miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   memory_responder #(.RegBits(RegBits), .DepthBits(DepthBits), .Latency(2)) dut (
      .clk_i(clk), .rst_i(rst_n[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
      .req_write_i(req_write[0]), .req_size_i(req_size[0]), .req_wdata_i(req_wdata[0]),
      .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
      .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
   );

   memory_responder #(.RegBits(RegBits), .DepthBits(DepthBits), .Latency(4)) dut4 (
      .clk_i(clk), .rst_i(rst_n[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
      .req_write_i(req_write[1]), .req_size_i(req_size[1]), .req_wdata_i(req_wdata[1]),
      .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
      .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
   );

   // Present one request and return #1 after its accept edge.
   task automatic issue(input int k, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
      int guard;
      guard = 0;
      while (req_ready[k] !== 1'b1 && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      req_valid[k] = 1'b1; req_write[k] = wr; req_size[k] = sz;
      req_addr[k]  = addr; req_wdata[k] = wd;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
   endtask

   // Count edges after the accept edge until the response shows up (bounded).
   task automatic wait_resp(input int k, output int cyc);
      cyc = 0;
      while (resp_valid[k] !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic access(input int k, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int cyc);
      issue(k, wr, sz, addr, wd);
      wait_resp(k, cyc);
      rd  = resp_rdata[k];
      err = resp_err[k];
      resp_ready[k] = 1'b1;
      @(posedge clk); #1;
      resp_ready[k] = 1'b0;
      $display("dut%0d %s size=%0d addr=%h wdata=%h -> rdata=%h err=%b edges=%0d",
               k, wr ? "store" : "load ", sz, addr, wd, rd, err, cyc);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         vectors++; if (req_ready[k] !== 1'b0) begin miscompares++; $display("FAIL rst_ready%0d: got %b expected 0", k, req_ready[k]); end
         vectors++; if (resp_valid[k] !== 1'b0) begin miscompares++; $display("FAIL rst_valid%0d: got %b expected 0", k, resp_valid[k]); end
         vectors++; if (resp_rdata[k] !== 32'h0) begin miscompares++; $display("FAIL rst_rdata%0d: got %h expected 0", k, resp_rdata[k]); end
         vectors++; if (resp_err[k] !== 1'b0) begin miscompares++; $display("FAIL rst_err%0d: got %b expected 0", k, resp_err[k]); end
      end
      rst_n = 2'b11;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         vectors++; if (req_ready[k] !== 1'b1) begin miscompares++; $display("FAIL rel_ready%0d: got %b expected 1", k, req_ready[k]); end
      end
   endtask

   task automatic test_word;
      logic [31:0] rd; logic err; int cyc;
      access(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, err, cyc);
      vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL st_latency: got %0d expected 1", cyc); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL st_rdata: got %h expected 0", rd); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL st_err: got %b expected 0", err); end
      access(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, err, cyc);
      vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL ld_latency: got %0d expected 1", cyc); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_word: got %h expected deadbeef", rd); end
   endtask

   task automatic test_lanes;
      logic [31:0] rd; logic err; int cyc;
      access(0, 1'b1, 2'b10, 32'h10, 32'h11223344, rd, err, cyc);
      access(0, 1'b1, 2'b00, 32'h13, 32'hFFFFFFAA, rd, err, cyc);
      access(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'hAA223344) begin miscompares++; $display("FAIL byte_merge: got %h expected aa223344", rd); end
      access(0, 1'b0, 2'b00, 32'h13, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'h000000AA) begin miscompares++; $display("FAIL byte_load3: got %h expected 000000aa", rd); end
      access(0, 1'b0, 2'b00, 32'h11, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'h00000033) begin miscompares++; $display("FAIL byte_load1: got %h expected 00000033", rd); end
      access(0, 1'b1, 2'b01, 32'h12, 32'h1234BEEF, rd, err, cyc);
      access(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'hBEEF3344) begin miscompares++; $display("FAIL half_merge: got %h expected beef3344", rd); end
      access(0, 1'b0, 2'b01, 32'h12, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'h0000BEEF) begin miscompares++; $display("FAIL half_load: got %h expected 0000beef", rd); end
   endtask

   task automatic test_backpressure;
      logic [31:0] rd; logic err; int cyc;
      issue(0, 1'b0, 2'b10, 32'h10, 32'h0);
      wait_resp(0, cyc);
      // A competing store is offered while the response is held; it must be ignored.
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'b10;
      req_addr[0]  = 32'h10; req_wdata[0] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         vectors++; if (resp_valid[0] !== 1'b1) begin miscompares++; $display("FAIL hold_valid c%0d: got %b expected 1", i, resp_valid[0]); end
         vectors++; if (resp_rdata[0] !== 32'hBEEF3344) begin miscompares++; $display("FAIL hold_rdata c%0d: got %h expected beef3344", i, resp_rdata[0]); end
         vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL hold_ready c%0d: got %b expected 0", i, req_ready[0]); end
         @(posedge clk); #1;
      end
      req_valid[0] = 1'b0;
      resp_ready[0] = 1'b1;
      @(posedge clk); #1;
      resp_ready[0] = 1'b0;
      vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL post_ready: got %b expected 1", req_ready[0]); end
      vectors++; if (resp_valid[0] !== 1'b0) begin miscompares++; $display("FAIL post_valid: got %b expected 0", resp_valid[0]); end
      access(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'hBEEF3344) begin miscompares++; $display("FAIL ignored_req: got %h expected beef3344", rd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; int cyc;
      resp_ready[0] = 1'b1;
      issue(0, 1'b1, 2'b10, 32'h30, 32'h00000077);
      wait_resp(0, cyc);
      vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL b2b_st_latency: got %0d expected 1", cyc); end
      @(posedge clk); #1;
      vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", req_ready[0]); end
      issue(0, 1'b0, 2'b10, 32'h30, 32'h0);
      wait_resp(0, cyc);
      rd = resp_rdata[0];
      vectors++; if (rd !== 32'h00000077) begin miscompares++; $display("FAIL b2b_load: got %h expected 00000077", rd); end
      @(posedge clk); #1;
      resp_ready[0] = 1'b0;
      $display("dut0 back-to-back store/load addr=00000030 -> rdata=%h", rd);
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd; logic err; int cyc;
      access(1, 1'b1, 2'b10, 32'h20, 32'h0BADF00D, rd, err, cyc);
      vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL lat4_latency: got %0d expected 3", cyc); end
      issue(1, 1'b1, 2'b10, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      rst_n[1] = 1'b0;
      #1;
      vectors++; if (req_ready[1] !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b expected 0", req_ready[1]); end
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (resp_valid[1] !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b expected 0", resp_valid[1]); end
      rst_n[1] = 1'b1;
      @(posedge clk); #1;
      vectors++; if (req_ready[1] !== 1'b1) begin miscompares++; $display("FAIL abort_rel_ready: got %b expected 1", req_ready[1]); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (resp_valid[1] !== 1'b0) begin miscompares++; $display("FAIL abort_noresp c%0d: got %b expected 0", i, resp_valid[1]); end
         @(posedge clk); #1;
      end
      access(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL abort_mem: got %h expected 0badf00d", rd); end
   endtask

   task automatic test_misaligned;
      logic [31:0] rd; logic err; int cyc;
      access(0, 1'b1, 2'b10, 32'h20, 32'h55667788, rd, err, cyc);
      access(0, 1'b1, 2'b01, 32'h21, 32'h0000CAFE, rd, err, cyc);
      vectors++; if (err !== ErrEn) begin miscompares++; $display("FAIL mis_half_err: got %b expected %b", err, ErrEn); end
      vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL mis_half_latency: got %0d expected 1", cyc); end
      access(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, err, cyc);
      vectors++; if (rd !== (ErrEn ? 32'h55667788 : 32'h5566CAFE)) begin miscompares++; $display("FAIL mis_half_mem: got %h expected %h", rd, ErrEn ? 32'h55667788 : 32'h5566CAFE); end
      access(0, 1'b0, 2'b10, 32'h22, 32'h0, rd, err, cyc);
      vectors++; if (err !== ErrEn) begin miscompares++; $display("FAIL mis_word_err: got %b expected %b", err, ErrEn); end
      vectors++; if (rd !== (ErrEn ? 32'h0 : 32'h5566CAFE)) begin miscompares++; $display("FAIL mis_word_rdata: got %h expected %h", rd, ErrEn ? 32'h0 : 32'h5566CAFE); end
      access(0, 1'b1, 2'b10, 32'h24, 32'hA5A5A5A5, rd, err, cyc);
      access(0, 1'b1, 2'b11, 32'h24, 32'h01020304, rd, err, cyc);
      vectors++; if (err !== ErrEn) begin miscompares++; $display("FAIL rsvd_err: got %b expected %b", err, ErrEn); end
      access(0, 1'b0, 2'b10, 32'h24, 32'h0, rd, err, cyc);
      vectors++; if (rd !== (ErrEn ? 32'hA5A5A5A5 : 32'h01020304)) begin miscompares++; $display("FAIL rsvd_mem: got %h expected %h", rd, ErrEn ? 32'hA5A5A5A5 : 32'h01020304); end
   endtask

   task automatic test_wrap;
      logic [31:0] rd; logic err; int cyc;
      access(0, 1'b1, 2'b10, 32'h400, 32'h600DCAFE, rd, err, cyc);
      access(0, 1'b0, 2'b10, 32'h000, 32'h0, rd, err, cyc);
      vectors++; if (rd !== 32'h600DCAFE) begin miscompares++; $display("FAIL wrap: got %h expected 600dcafe", rd); end
   endtask

   initial begin
      rst_n      = 2'b00;
      req_valid  = '0;
      req_addr   = '0;
      req_write  = '0;
      req_size   = '0;
      req_wdata  = '0;
      resp_ready = '0;
      test_reset();
      test_word();
      test_lanes();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_misaligned();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
